// File: rtl/data_writer_medium.sv
// Purpose: serializes one (x, y) sample into 2*PIECES consecutive BRAM words at addr_in*2*PIECES.
// Latency: first BRAM write the cycle after acceptance, 2*PIECES write cycles, finished_out one cycle later.
// Backpressure: ready_out=0 while busy; write_enable is ignored (not queued) until ready_out returns high.
//
// Ports:
//   clk_in, rst_in           clock, asynchronous active-high reset
//   addr_in, x_in, y_in      request address and sample data, sampled on the accepting edge
//   write_enable             request strobe, taken only while ready_out=1
//   ready_out, finished_out  idle indication, one-cycle completion pulse
//   bram_addr/we/regce/din   BRAM write port (regce tied low)
module data_writer_medium #(
  parameter int ADDRS      = 1024,
  parameter int BRAM_WIDTH = 64,
  parameter int PIECES     = 16
) (
  input  logic                                 clk_in,
  input  logic                                 rst_in,
  input  logic [$clog2(ADDRS)-1:0]             addr_in,
  input  logic [PIECES*BRAM_WIDTH-1:0]         x_in,
  input  logic [PIECES*BRAM_WIDTH-1:0]         y_in,
  input  logic                                 write_enable,
  output logic                                 ready_out,
  output logic                                 finished_out,
  output logic [$clog2(ADDRS*PIECES*2)-1:0]    bram_addr,
  output logic                                 bram_we,
  output logic                                 bram_regce,
  output logic [BRAM_WIDTH-1:0]                bram_din
);

  localparam int NP  = 2 * PIECES;
  localparam int AW  = $clog2(ADDRS);
  localparam int BAW = $clog2(ADDRS * NP);
  localparam int KW  = $clog2(NP);
  localparam int SW  = NP * BRAM_WIDTH;
  localparam logic [KW-1:0]  LAST_PIECE = KW'(NP - 1);
  localparam logic [BAW-1:0] NP_B       = BAW'(NP);

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  state_t          state;
  logic [SW-1:0]   shift_buf;   // pieces still to be written, next one in the low word
  logic [KW-1:0]   piece;       // index of the piece currently on bram_din
  logic [BAW-1:0]  base;
  logic            addr_ok;

  // Widen before multiplying so the top logical address cannot overflow.
  assign base = BAW'(addr_in) * NP_B;

  // Out-of-range addresses only exist when ADDRS is not a power of two.
  generate
    if (ADDRS == (1 << AW)) begin : g_pow2
      assign addr_ok = 1'b1;
    end else begin : g_npow2
      assign addr_ok = (int'(addr_in) < ADDRS);
    end
  endgenerate

  assign bram_regce = 1'b0;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state        <= IDLE;
      ready_out    <= 1'b1;
      finished_out <= 1'b0;
      bram_we      <= 1'b0;
      bram_addr    <= '0;
      bram_din     <= '0;
      piece        <= '0;
      shift_buf    <= '0;
    end else begin
      case (state)
        IDLE: begin
          finished_out <= 1'b0;
          if (write_enable && addr_ok) begin
            // Piece 0 goes straight to the output register; the rest wait in the buffer.
            state     <= WRITE;
            ready_out <= 1'b0;
            bram_we   <= 1'b1;
            bram_addr <= base;
            bram_din  <= y_in[BRAM_WIDTH-1:0];
            shift_buf <= {x_in, y_in} >> BRAM_WIDTH;
            piece     <= '0;
          end
        end
        WRITE: begin
          if (piece == LAST_PIECE) begin
            // Address and data hold their last values once the write strobe drops.
            state        <= DONE;
            bram_we      <= 1'b0;
            finished_out <= 1'b1;
          end else begin
            piece     <= piece + 1'b1;
            bram_addr <= bram_addr + 1'b1;
            bram_din  <= shift_buf[BRAM_WIDTH-1:0];
            shift_buf <= shift_buf >> BRAM_WIDTH;
          end
        end
        DONE: begin
          finished_out <= 1'b0;
          ready_out    <= 1'b1;
          state        <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
